wb_commit_unit: RTL and testbench

- Writeback-side consumer of the MEM/WB pipeline bundle.
- Resolves the final register-file write: result select, lb byte extraction/extension, movn/movz gating, $0 suppression.
- Registers the write toward the register file and keeps a 2-entry history of committed writes.
- ID/EX forwarding logic queries that history through two lookup ports.

---
 rtl/wb_commit_unit.sv | 161 ++++++++++++++++
 tb/tb_wb_commit_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_unit.sv
// wb_commit_unit: writeback commit stage that registers the regfile write and keeps a 2-entry write history for forwarding.
// Defining WB_RETIRE_COUNT_EN adds the RetireCountOut commit counter.
module wb_commit_unit #(
  parameter int COUNT_WIDTH = 32,
  parameter int ADDR_WIDTH  = 5
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  StallIn,
  input  logic                  RegWriteIn,
  input  logic                  MoveNotZeroIn,
  input  logic                  DontMoveIn,
  input  logic                  HiOrLoIn,
  input  logic                  MemToRegIn,
  input  logic                  HiLoToRegIn,
  input  logic                  ZeroIn,
  input  logic                  LbIn,
  input  logic                  LoadExtendedIn,
  input  logic                  MemReadIn,
  input  logic [31:0]           RHiIn,
  input  logic [31:0]           RLoIn,
  input  logic [31:0]           ALUResultIn,
  input  logic [31:0]           ReadDataIn,
  input  logic [ADDR_WIDTH-1:0] WriteAddressIn,
  input  logic [ADDR_WIDTH-1:0] LookupAddrA,
  input  logic [ADDR_WIDTH-1:0] LookupAddrB,
  output logic                  RegWriteEnOut,
  output logic [ADDR_WIDTH-1:0] RegWriteAddrOut,
  output logic [31:0]           RegWriteDataOut,
  output logic                  HitA,
  output logic                  HitB,
  output logic [31:0]           FwdDataA,
  output logic [31:0]           FwdDataB,
  output logic                  LoadRetiredOut
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] RetireCountOut
`endif
);

  localparam int DATA_W = 32;

  if (COUNT_WIDTH < 1) begin : g_bad_count_width
    $error("COUNT_WIDTH must be at least 1");
  end

  // Big-endian byte pick from a loaded word, sign- or zero-extended.
  function automatic logic [DATA_W-1:0] lb_extract(input logic [DATA_W-1:0] word,
                                                   input logic [1:0] sel,
                                                   input logic sext);
    logic signed [7:0]        b;
    logic signed [DATA_W-1:0] wide;
    case (sel)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    wide = b;
    return sext ? wide : {24'd0, b};
  endfunction

  // Returns {hit, data}; entry0 is newest and wins, register 0 never hits.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_WIDTH-1:0] q,
                                             input logic v0, input logic [ADDR_WIDTH-1:0] a0,
                                             input logic [DATA_W-1:0] d0,
                                             input logic v1, input logic [ADDR_WIDTH-1:0] a1,
                                             input logic [DATA_W-1:0] d1);
    if (q == '0)            return '0;
    if (v0 && (a0 == q))    return {1'b1, d0};
    if (v1 && (a1 == q))    return {1'b1, d1};
    return '0;
  endfunction

  logic                     gate;
  logic                     commit;
  logic signed [DATA_W-1:0] result;

  logic                     vld_p1;
  logic                     load_p1;
  logic [ADDR_WIDTH-1:0]    addr_p1;
  logic signed [DATA_W-1:0] data_p1;

  logic                     hist_vld_p1  [2];
  logic [ADDR_WIDTH-1:0]    hist_addr_p1 [2];
  logic [DATA_W-1:0]        hist_data_p1 [2];

  always_comb begin
    result = ALUResultIn;
    if (HiLoToRegIn)
      result = HiOrLoIn ? RHiIn : RLoIn;
    else if (MemToRegIn && LbIn)
      result = lb_extract(ReadDataIn, ALUResultIn[1:0], LoadExtendedIn);
    else if (MemToRegIn)
      result = ReadDataIn;
  end

  always_comb begin
    case ({MoveNotZeroIn, DontMoveIn})
      2'b00:   gate = 1'b1;
      2'b10:   gate = !ZeroIn;
      2'b01:   gate = ZeroIn;
      default: gate = 1'b0;
    endcase
    commit = RegWriteIn && (WriteAddressIn != '0) && !StallIn && gate;
  end

  // ---- stage p0 -> p1: registered write and history shift ----
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      vld_p1  <= 1'b0;
      load_p1 <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
      for (int i = 0; i < 2; i++) begin
        hist_vld_p1[i]  <= 1'b0;
        hist_addr_p1[i] <= '0;
        hist_data_p1[i] <= '0;
      end
    end else begin
      vld_p1  <= commit;
      load_p1 <= commit && MemReadIn;
      if (commit) begin
        addr_p1         <= WriteAddressIn;
        data_p1         <= result;
        hist_vld_p1[1]  <= hist_vld_p1[0];
        hist_addr_p1[1] <= hist_addr_p1[0];
        hist_data_p1[1] <= hist_data_p1[0];
        hist_vld_p1[0]  <= 1'b1;
        hist_addr_p1[0] <= WriteAddressIn;
        hist_data_p1[0] <= result;
      end
    end
  end

  assign RegWriteEnOut   = vld_p1;
  assign RegWriteAddrOut = addr_p1;
  assign RegWriteDataOut = data_p1;
  assign LoadRetiredOut  = load_p1;

  assign {HitA, FwdDataA} = lookup(LookupAddrA,
                                   hist_vld_p1[0], hist_addr_p1[0], hist_data_p1[0],
                                   hist_vld_p1[1], hist_addr_p1[1], hist_data_p1[1]);
  assign {HitB, FwdDataB} = lookup(LookupAddrB,
                                   hist_vld_p1[0], hist_addr_p1[0], hist_data_p1[0],
                                   hist_vld_p1[1], hist_addr_p1[1], hist_data_p1[1]);

`ifdef WB_RETIRE_COUNT_EN
  logic [COUNT_WIDTH-1:0] cnt_p1;

  always_ff @(posedge Clk) begin
    if (!Rst_n)
      cnt_p1 <= '0;
    else if (commit)
      cnt_p1 <= cnt_p1 + COUNT_WIDTH'(1);
  end

  assign RetireCountOut = cnt_p1;
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// tb_wb_commit_unit: vector table, directed history/reset sequences and random traffic against a queue-based model.
// Define WB_RETIRE_COUNT_EN to also exercise the 4-bit retire counter.
module tb_wb_commit_unit;
  localparam int AW = 5;
`ifdef WB_RETIRE_COUNT_EN
  localparam int CW = 4;
`else
  localparam int CW = 32;
`endif

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic StallIn, RegWriteIn, MoveNotZeroIn, DontMoveIn, HiOrLoIn, MemToRegIn;
  logic HiLoToRegIn, ZeroIn, LbIn, LoadExtendedIn, MemReadIn;
  logic [31:0] RHiIn, RLoIn, ALUResultIn, ReadDataIn;
  logic [AW-1:0] WriteAddressIn, LookupAddrA, LookupAddrB;
  logic RegWriteEnOut, HitA, HitB, LoadRetiredOut;
  logic [AW-1:0] RegWriteAddrOut;
  logic [31:0] RegWriteDataOut, FwdDataA, FwdDataB;
`ifdef WB_RETIRE_COUNT_EN
  logic [CW-1:0] RetireCountOut;
`endif

  wb_commit_unit #(.COUNT_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .StallIn(StallIn), .RegWriteIn(RegWriteIn),
    .MoveNotZeroIn(MoveNotZeroIn), .DontMoveIn(DontMoveIn), .HiOrLoIn(HiOrLoIn),
    .MemToRegIn(MemToRegIn), .HiLoToRegIn(HiLoToRegIn), .ZeroIn(ZeroIn), .LbIn(LbIn),
    .LoadExtendedIn(LoadExtendedIn), .MemReadIn(MemReadIn), .RHiIn(RHiIn), .RLoIn(RLoIn),
    .ALUResultIn(ALUResultIn), .ReadDataIn(ReadDataIn), .WriteAddressIn(WriteAddressIn),
    .LookupAddrA(LookupAddrA), .LookupAddrB(LookupAddrB), .RegWriteEnOut(RegWriteEnOut),
    .RegWriteAddrOut(RegWriteAddrOut), .RegWriteDataOut(RegWriteDataOut), .HitA(HitA),
    .HitB(HitB), .FwdDataA(FwdDataA), .FwdDataB(FwdDataB), .LoadRetiredOut(LoadRetiredOut)
`ifdef WB_RETIRE_COUNT_EN
    , .RetireCountOut(RetireCountOut)
`endif
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;

  typedef struct { logic [AW-1:0] a; logic [31:0] d; } hent_t;
  hent_t hist[$];
  logic m_en, m_load;
  logic [AW-1:0] m_addr;
  logic [31:0] m_data;
  longint m_cnt;

  typedef struct {
    logic rw, mnz, dm, hol, m2r, hl2r, z, lb, lext, mrd;
    logic [31:0] hi, lo, alu, rd;
    logic [AW-1:0] wa;
    logic en;
    logic [31:0] data;
    logic ld;
  } vec_t;
  vec_t vecs[15];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] model_result();
    logic [31:0] b;
    int k;
    if (HiLoToRegIn) return HiOrLoIn ? RHiIn : RLoIn;
    if (MemToRegIn && LbIn) begin
      k = 3 - int'(ALUResultIn[1:0]);
      b = (ReadDataIn >> (8 * k)) & 32'hFF;
      if (LoadExtendedIn && b[7]) b = b | 32'hFFFF_FF00;
      return b;
    end
    if (MemToRegIn) return ReadDataIn;
    return ALUResultIn;
  endfunction

  function automatic logic model_writes();
    if (!RegWriteIn || StallIn || WriteAddressIn == 0) return 1'b0;
    if (MoveNotZeroIn && DontMoveIn) return 1'b0;
    if (MoveNotZeroIn && ZeroIn) return 1'b0;
    if (DontMoveIn && !ZeroIn) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [32:0] model_lookup(logic [AW-1:0] q);
    if (q == 0) return 33'd0;
    foreach (hist[i]) if (hist[i].a == q) return {1'b1, hist[i].d};
    return 33'd0;
  endfunction

  task automatic clear_bundle();
    {StallIn, RegWriteIn, MoveNotZeroIn, DontMoveIn, HiOrLoIn, MemToRegIn} = '0;
    {HiLoToRegIn, ZeroIn, LbIn, LoadExtendedIn, MemReadIn} = '0;
    RHiIn = 0; RLoIn = 0; ALUResultIn = 0; ReadDataIn = 0; WriteAddressIn = 0;
  endtask

  task automatic wr_alu(logic [AW-1:0] a, logic [31:0] d);
    clear_bundle();
    RegWriteIn = 1'b1; WriteAddressIn = a; ALUResultIn = d;
  endtask

  // One clock: model follows the rules for the bundle presented before the edge.
  task automatic tick();
    logic w;
    logic [31:0] r;
    w = model_writes();
    r = model_result();
    @(posedge Clk);
    if (!Rst_n) begin
      m_en = 0; m_load = 0; m_addr = 0; m_data = 0; m_cnt = 0;
      hist.delete();
    end else begin
      m_en = w;
      m_load = w && MemReadIn;
      if (w) begin
        m_addr = WriteAddressIn;
        m_data = r;
        hist.push_front('{a: WriteAddressIn, d: r});
        if (hist.size() > 2) void'(hist.pop_back());
        m_cnt = (m_cnt + 1) % (longint'(1) << CW);
      end
    end
    #1;
  endtask

  task automatic check_all(logic [AW-1:0] qa, logic [AW-1:0] qb);
    logic [32:0] ea, eb;
    LookupAddrA = qa; LookupAddrB = qb;
    #1;
    ea = model_lookup(qa);
    eb = model_lookup(qb);
    chk("en", 32'(RegWriteEnOut), 32'(m_en));
    chk("addr", 32'(RegWriteAddrOut), 32'(m_addr));
    chk("data", RegWriteDataOut, m_data);
    chk("load", 32'(LoadRetiredOut), 32'(m_load));
    chk("hitA", 32'(HitA), 32'(ea[32]));
    chk("fwdA", FwdDataA, ea[31:0]);
    chk("hitB", 32'(HitB), 32'(eb[32]));
    chk("fwdB", FwdDataB, eb[31:0]);
`ifdef WB_RETIRE_COUNT_EN
    chk("count", 32'(RetireCountOut), 32'(m_cnt));
`endif
  endtask

  initial begin
    clear_bundle();
    LookupAddrA = 0; LookupAddrB = 0;
    m_en = 0; m_load = 0; m_addr = 0; m_data = 0; m_cnt = 0;

    //          rw mnz dm hol m2r hl2r z lb lext mrd  hi            lo            alu           rd            wa  en data          ld
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h1234_5678, 32'h0, 8, 1, 32'h1234_5678, 0};
    vecs[1]  = '{1, 0, 0, 0, 1, 0, 0, 1, 1, 1, 32'h0, 32'h0, 32'h0000_0001, 32'h11F2_3344, 10, 1, 32'hFFFF_FFF2, 1};
    vecs[2]  = '{1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 32'h0, 32'h0, 32'h0000_0001, 32'h11F2_3344, 11, 1, 32'h0000_00F2, 1};
    vecs[3]  = '{1, 0, 0, 0, 1, 0, 0, 1, 1, 1, 32'h0, 32'h0, 32'h0000_0000, 32'h11F2_3344, 12, 1, 32'h0000_0011, 1};
    vecs[4]  = '{1, 0, 0, 0, 1, 0, 0, 1, 1, 1, 32'h0, 32'h0, 32'h0000_0003, 32'h11F2_3384, 13, 1, 32'hFFFF_FF84, 1};
    vecs[5]  = '{1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h0000_0002, 32'h11F2_A344, 14, 1, 32'h0000_00A3, 0};
    vecs[6]  = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0000_0003, 32'hDEAD_BEEF, 15, 1, 32'hDEAD_BEEF, 1};
    vecs[7]  = '{1, 0, 0, 1, 1, 1, 0, 1, 0, 0, 32'hAAAA_0001, 32'h5555, 32'h7, 32'h9, 16, 1, 32'hAAAA_0001, 0};
    vecs[8]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'hAAAA_0001, 32'h5555, 32'h7, 32'h9, 17, 1, 32'h0000_5555, 0};
    vecs[9]  = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0077, 32'h0, 18, 0, 32'h0, 0};
    vecs[10] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0078, 32'h0, 19, 1, 32'h0000_0078, 0};
    vecs[11] = '{1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0079, 32'h0, 9, 1, 32'h0000_0079, 0};
    vecs[12] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_007A, 32'h0, 20, 0, 32'h0, 0};
    vecs[13] = '{1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0000_007B, 32'h0, 21, 0, 32'h0, 0};
    vecs[14] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_007C, 32'h0, 0, 0, 32'h0, 0};

    // Reset held two cycles with a valid bundle presented.
    Rst_n = 1'b0;
    wr_alu(5, 32'h5555_AAAA);
    tick(); tick();
    check_all(5, 5);
    chk("rst_en", 32'(RegWriteEnOut), 32'd0);
    chk("rst_hitA", 32'(HitA), 32'd0);
`ifdef WB_RETIRE_COUNT_EN
    chk("rst_count", 32'(RetireCountOut), 32'd0);
`endif
    Rst_n = 1'b1;

    foreach (vecs[i]) begin
      clear_bundle();
      RegWriteIn = vecs[i].rw; MoveNotZeroIn = vecs[i].mnz; DontMoveIn = vecs[i].dm;
      HiOrLoIn = vecs[i].hol; MemToRegIn = vecs[i].m2r; HiLoToRegIn = vecs[i].hl2r;
      ZeroIn = vecs[i].z; LbIn = vecs[i].lb; LoadExtendedIn = vecs[i].lext;
      MemReadIn = vecs[i].mrd; RHiIn = vecs[i].hi; RLoIn = vecs[i].lo;
      ALUResultIn = vecs[i].alu; ReadDataIn = vecs[i].rd; WriteAddressIn = vecs[i].wa;
      tick();
      check_all(vecs[i].wa, 5'(8));
      chk($sformatf("vec%0d_en", i), 32'(RegWriteEnOut), 32'(vecs[i].en));
      if (vecs[i].en) begin
        chk($sformatf("vec%0d_addr", i), 32'(RegWriteAddrOut), 32'(vecs[i].wa));
        chk($sformatf("vec%0d_data", i), RegWriteDataOut, vecs[i].data);
        chk($sformatf("vec%0d_ld", i), 32'(LoadRetiredOut), 32'(vecs[i].ld));
        chk($sformatf("vec%0d_hit", i), 32'(HitA), 32'd1);
        chk($sformatf("vec%0d_fwd", i), FwdDataA, vecs[i].data);
      end
    end

    // History ordering, $0 suppression, stall hold, same-cycle invisibility.
    Rst_n = 1'b0; clear_bundle(); tick(); Rst_n = 1'b1;
    wr_alu(3, 32'hA); tick();
    wr_alu(3, 32'hB); tick();
    wr_alu(4, 32'hC); tick();
    check_all(3, 4);
    chk("hist_r3", FwdDataA, 32'hB);
    chk("hist_r4", FwdDataB, 32'hC);
    wr_alu(0, 32'hDEAD); tick();
    check_all(3, 0);
    chk("r0_en", 32'(RegWriteEnOut), 32'd0);
    chk("r0_hist", FwdDataA, 32'hB);
    chk("r0_nohit", 32'(HitB), 32'd0);
    wr_alu(5, 32'h55); StallIn = 1'b1; tick();
    check_all(5, 4);
    chk("stall_en", 32'(RegWriteEnOut), 32'd0);
    chk("stall_miss", 32'(HitA), 32'd0);
    wr_alu(6, 32'h66);
    LookupAddrA = 6; #1;
    chk("same_cycle_miss", 32'(HitA), 32'd0);
    tick();
    check_all(6, 3);
    chk("next_cycle_hit", FwdDataA, 32'h66);
    wr_alu(7, 32'h77); Rst_n = 1'b0; tick(); Rst_n = 1'b1;
    check_all(7, 6);
    chk("midrst_en", 32'(RegWriteEnOut), 32'd0);
    chk("midrst_hist", 32'(HitB), 32'd0);

`ifdef WB_RETIRE_COUNT_EN
    for (int i = 0; i < 17; i++) begin
      wr_alu(5'(i % 7 + 1), 32'(i)); tick();
    end
    check_all(1, 2);
    chk("count_wrap", 32'(RetireCountOut), 32'd1);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      Rst_n = ($urandom_range(0, 39) != 0);
      StallIn = ($urandom_range(0, 4) == 0);
      RegWriteIn = ($urandom_range(0, 3) != 0);
      MoveNotZeroIn = ($urandom_range(0, 3) == 0);
      DontMoveIn = ($urandom_range(0, 3) == 0);
      {HiOrLoIn, MemToRegIn, ZeroIn, LbIn, LoadExtendedIn, MemReadIn} = 6'($urandom);
      HiLoToRegIn = ($urandom_range(0, 3) == 0);
      RHiIn = $urandom; RLoIn = $urandom; ALUResultIn = $urandom; ReadDataIn = $urandom;
      WriteAddressIn = 5'($urandom_range(0, 7));
      tick();
      check_all(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
